// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver (MSB first) with a one-entry ready/valid holding register.
// Define UART_RX_SYNC_EN to insert a two-flop synchronizer on rx for asynchronous pins.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       framing_err,
  output logic       overrun
);

  localparam int unsigned Half = CLKS_PER_BIT / 2;
  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] HalfLast = CntW'((Half > 0) ? Half - 1 : 0);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shreg_q;
  logic            rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      data        <= '0;
      valid       <= 1'b0;
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      framing_err <= 1'b0;
      overrun     <= 1'b0;
      // A completing byte below overrides this clear when both happen together.
      if (valid && ready) begin
        valid <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (!rx_s) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= (Half == 0) ? StData : StStart;
          end
        end
        StStart: begin
          if (cnt_q == HalfLast) begin
            cnt_q   <= '0;
            state_q <= rx_s ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == BitLast) begin
            cnt_q   <= '0;
            shreg_q <= {shreg_q[6:0], rx_s};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              state_q <= StStop;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (cnt_q == BitLast) begin
            cnt_q <= '0;
            if (rx_s) begin
              state_q <= StIdle;
              if (!valid || ready) begin
                data  <= shreg_q;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              framing_err <= 1'b1;
              state_q     <= StBreak;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StBreak: begin
          // Hold off until the line recovers so a stuck-low line cannot frame again.
          if (rx_s) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two instances (1 and 16 clocks per bit), directed scenarios with literal
// expectations, then random line activity checked every cycle against a sample-time model.
module tb_uart_rx;

  localparam int Cpb0 = 1;
  localparam int Cpb1 = 16;
`ifdef UART_RX_SYNC_EN
  localparam int Sync = 2;
`else
  localparam int Sync = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rx_l, rdy_l, rst_l;
  logic [1:0] val_l, fe_l, ov_l;
  logic [7:0] dat_l [2];

  uart_rx #(.CLKS_PER_BIT(Cpb0)) u_dut0 (
    .CLK(clk), .RESET(rst_l[0]), .rx(rx_l[0]), .data(dat_l[0]), .valid(val_l[0]),
    .ready(rdy_l[0]), .framing_err(fe_l[0]), .overrun(ov_l[0])
  );
  uart_rx #(.CLKS_PER_BIT(Cpb1)) u_dut1 (
    .CLK(clk), .RESET(rst_l[1]), .rx(rx_l[1]), .data(dat_l[1]), .valid(val_l[1]),
    .ready(rdy_l[1]), .framing_err(fe_l[1]), .overrun(ov_l[1])
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string name, int ch, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s ch%0d actual=0x%0h required=0x%0h t=%0t", name, ch, act, exp, $time);
    end
  endtask

  function automatic int cpb_of(int ch);
    return (ch == 0) ? Cpb0 : Cpb1;
  endfunction

  // Reference model: line samples kept by cycle number; each frame is decoded by looking
  // back at the samples at t0+H, t0+H+k*CPB and t0+H+9*CPB.
  int         cyc = 0;
  logic       hist [2][4096];
  int         m_st [2];  // 0 free, 1 inside a frame, 2 waiting for line high after bad stop
  int         m_t0 [2];
  logic [1:0] m_sy [2];
  logic       m_valid [2];
  logic       m_fe [2];
  logic       m_ov [2];
  logic [7:0] m_data [2];
  bit         model_on = 1'b0;

  task automatic model_step(int ch);
    int cpb, h, rel;
    logic ls, done, fe, ov;
    logic [7:0] b;
    cpb = cpb_of(ch);
    h = cpb / 2;
    if (rst_l[ch]) begin
      m_st[ch] = 0; m_sy[ch] = 2'b11; m_valid[ch] = 1'b0; m_data[ch] = 8'h00;
      m_fe[ch] = 1'b0; m_ov[ch] = 1'b0;
      return;
    end
    ls = (Sync != 0) ? m_sy[ch][1] : rx_l[ch];
    m_sy[ch] = {m_sy[ch][0], rx_l[ch]};
    hist[ch][cyc % 4096] = ls;
    done = 1'b0; fe = 1'b0; ov = 1'b0; b = 8'h00;
    if (m_st[ch] == 0 && !ls) begin
      m_st[ch] = 1;
      m_t0[ch] = cyc;
    end else if (m_st[ch] == 2 && ls) begin
      m_st[ch] = 0;
    end else if (m_st[ch] == 1) begin
      rel = cyc - m_t0[ch];
      if (h > 0 && rel == h && ls) begin
        m_st[ch] = 0;
      end else if (rel == h + 9 * cpb) begin
        for (int k = 1; k <= 8; k++) b = {b[6:0], hist[ch][(m_t0[ch] + h + cpb * k) % 4096]};
        if (ls) begin done = 1'b1; m_st[ch] = 0; end
        else begin fe = 1'b1; m_st[ch] = 2; end
      end
    end
    if (done) begin
      if (!m_valid[ch] || rdy_l[ch]) begin m_data[ch] = b; m_valid[ch] = 1'b1; end
      else ov = 1'b1;
    end else if (m_valid[ch] && rdy_l[ch]) begin
      m_valid[ch] = 1'b0;
    end
    m_fe[ch] = fe;
    m_ov[ch] = ov;
  endtask

  initial forever begin
    @(posedge clk);
    for (int ch = 0; ch < 2; ch++) model_step(ch);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (model_on) begin
      for (int ch = 0; ch < 2; ch++) begin
        chk("valid", ch, int'(val_l[ch]), int'(m_valid[ch]));
        chk("framing_err", ch, int'(fe_l[ch]), int'(m_fe[ch]));
        chk("overrun", ch, int'(ov_l[ch]), int'(m_ov[ch]));
        if (m_valid[ch]) chk("data", ch, int'(dat_l[ch]), int'(m_data[ch]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(int ch, logic b);
    rx_l[ch] = b;
    repeat (cpb_of(ch)) tick();
  endtask

  task automatic send_frame(int ch, logic [7:0] byt, logic stop);
    send_bit(ch, 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(ch, byt[i]);
    send_bit(ch, stop);
  endtask

  task automatic wait_valid(int ch, int lim, output int n);
    n = 0;
    while (!val_l[ch] && n < lim) begin
      tick();
      n++;
    end
  endtask

  task automatic lat_frame(string name, int ch, logic [7:0] byt, int exp_lat);
    int n;
    fork
      send_frame(ch, byt, 1'b1);
      wait_valid(ch, exp_lat + 20, n);
    join
    chk({name, "_latency"}, ch, n, exp_lat);
    chk({name, "_data"}, ch, int'(dat_l[ch]), int'(byt));
  endtask

  task automatic rand_run(int ch, int iters);
    int cpb;
    cpb = cpb_of(ch);
    for (int i = 0; i < iters; i++) begin
      int r;
      r = int'($urandom_range(0, 15));
      rdy_l[ch] = ($urandom_range(0, 3) != 0);
      if (r < 10) begin
        logic st;
        st = ($urandom_range(0, 5) != 0);
        send_frame(ch, 8'($urandom), st);
        if (!st) repeat ($urandom_range(0, 2)) send_bit(ch, 1'b0);
        rx_l[ch] = 1'b1;
        repeat ($urandom_range(0, 1)) send_bit(ch, 1'b1);
      end else if (r < 12) begin
        rx_l[ch] = 1'b0;
        repeat ($urandom_range(1, (cpb / 2 > 0) ? cpb / 2 : 1)) tick();
        rx_l[ch] = 1'b1;
        repeat (cpb * 2) tick();
      end else if (r < 13) begin
        send_bit(ch, 1'b0);
        repeat ($urandom_range(0, 8)) send_bit(ch, 1'($urandom_range(0, 1)));
        rst_l[ch] = 1'b1;
        tick();
        rst_l[ch] = 1'b0;
        rx_l[ch] = 1'b1;
        tick();
      end else begin
        rx_l[ch] = 1'b1;
        repeat ($urandom_range(1, 3 * cpb)) tick();
      end
    end
    rx_l[ch] = 1'b1;
    rdy_l[ch] = 1'b1;
    repeat (12 * cpb + 4) tick();
  endtask

  logic [7:0] b2b_exp [3] = '{8'h00, 8'hFF, 8'h81};

  initial begin
    int nv, nf, no;
    int at [3];
    int got [3];
    rx_l = 2'b11; rdy_l = 2'b11; rst_l = 2'b11;
    repeat (3) tick();
    rst_l = 2'b00;
    model_on = 1'b1;
    for (int ch = 0; ch < 2; ch++) begin
      chk("reset_valid", ch, int'(val_l[ch]), 0);
      chk("reset_data", ch, int'(dat_l[ch]), 0);
      chk("reset_fe", ch, int'(fe_l[ch]), 0);
      chk("reset_ov", ch, int'(ov_l[ch]), 0);
    end
    repeat (2) tick();

    // Single frame, CLKS_PER_BIT=1
    lat_frame("a5", 0, 8'hA5, 10 + Sync);
    chk("model_a5", 0, int'(m_data[0]), 8'hA5);
    tick();
    chk("a5_pulse", 0, int'(val_l[0]), 0);
    repeat (3) tick();

    // Back-to-back frames with no idle gap
    nv = 0;
    for (int i = 0; i < 3; i++) begin at[i] = 0; got[i] = 0; end
    fork
      begin
        for (int i = 0; i < 3; i++) send_frame(0, b2b_exp[i], 1'b1);
      end
      for (int i = 1; i <= 40; i++) begin
        tick();
        if (val_l[0]) begin
          if (nv < 3) begin at[nv] = i; got[nv] = int'(dat_l[0]); end
          nv++;
        end
      end
    join
    chk("b2b_count", 0, nv, 3);
    for (int i = 0; i < 3; i++) begin
      chk("b2b_time", 0, at[i], 10 * (i + 1) + Sync);
      chk("b2b_data", 0, got[i], int'(b2b_exp[i]));
    end

    // Bad stop bit followed by a held-low line
    nv = 0; nf = 0;
    fork
      begin
        send_frame(0, 8'h3C, 1'b0);
        repeat (20) tick();
        rx_l[0] = 1'b1;
        repeat (3) tick();
      end
      for (int i = 0; i < 45; i++) begin
        tick();
        nf += int'(fe_l[0]);
        nv += int'(val_l[0]);
      end
    join
    chk("fe_count", 0, nf, 1);
    chk("fe_no_valid", 0, nv, 0);
    lat_frame("5a", 0, 8'h5A, 10 + Sync);
    tick();

    // Overrun with the holding register full
    rdy_l[0] = 1'b0;
    no = 0;
    fork
      begin
        send_frame(0, 8'h11, 1'b1);
        send_frame(0, 8'h22, 1'b1);
      end
      for (int i = 0; i < 25; i++) begin
        tick();
        no += int'(ov_l[0]);
      end
    join
    chk("ovr_count", 0, no, 1);
    chk("ovr_valid", 0, int'(val_l[0]), 1);
    chk("ovr_data", 0, int'(dat_l[0]), 8'h11);
    chk("model_ovr", 0, int'(m_data[0]), 8'h11);
    rdy_l[0] = 1'b1;
    tick();
    chk("ovr_accept", 0, int'(val_l[0]), 0);

    // CLKS_PER_BIT=16: short glitch, then a real frame
    rx_l[1] = 1'b0;
    repeat (4) tick();
    rx_l[1] = 1'b1;
    nv = 0; nf = 0;
    for (int i = 0; i < 170; i++) begin
      tick();
      nv += int'(val_l[1]);
      nf += int'(fe_l[1]);
    end
    chk("glitch_valid", 1, nv, 0);
    chk("glitch_fe", 1, nf, 0);
    lat_frame("c3", 1, 8'hC3, 8 + 144 + 1 + Sync);
    tick();

    // Reset mid-frame while a byte is held
    rdy_l[1] = 1'b0;
    send_frame(1, 8'h99, 1'b1);
    repeat (4) tick();
    chk("held_valid", 1, int'(val_l[1]), 1);
    send_bit(1, 1'b0);
    send_bit(1, 1'b1);
    send_bit(1, 1'b0);
    send_bit(1, 1'b1);
    rx_l[1] = 1'b1;
    repeat (Cpb1 / 2) tick();
    rst_l[1] = 1'b1;
    tick();
    rst_l[1] = 1'b0;
    chk("rst_valid", 1, int'(val_l[1]), 0);
    chk("rst_data", 1, int'(dat_l[1]), 0);
    chk("rst_fe", 1, int'(fe_l[1]), 0);
    chk("rst_ov", 1, int'(ov_l[1]), 0);
    rx_l[1] = 1'b1;
    rdy_l[1] = 1'b1;
    repeat (20) tick();
    lat_frame("7e", 1, 8'h7E, 8 + 144 + 1 + Sync);
    tick();

    fork
      rand_run(0, 300);
      rand_run(1, 40);
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver for the one-start/eight-data/one-stop UART framing produced by the team's `uart_tx`: line idles high, start bit 0, data bits MSB first, stop bit 1, no parity. Recovers each byte, checks the stop bit, and presents the byte on a ready/valid output with a one-entry holding register. Sits between the external `rx` pin, or a loopback from `uart_tx`, and the byte-consuming logic. The default `CLKS_PER_BIT = 1` matches `uart_tx` cycle-for-cycle.

## Interface
- `CLKS_PER_BIT`, default 1: clock cycles per serial bit; must be ≥ 1.
- `CLK`  in  1  single clock; all state changes on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `rx`  in  1  serial line; idle high.
- `data`  out  8  received byte; valid only while `valid` is 1.
- `valid`  out  1  `data` holds an unconsumed byte.
- `ready`  in  1  consumer accepts `data` this cycle when `valid` is also 1.
- `framing_err`  out  1  one-cycle pulse: stop bit sampled 0; byte discarded.
- `overrun`  out  1  one-cycle pulse: a byte completed while the holding register was full and not being accepted; new byte dropped.

## Operation
- `rx_s` is the line value the FSM sees: `rx` directly, or the synchronized value under `UART_RX_SYNC_EN`.
- H = `CLKS_PER_BIT`/2 (integer division). Bit samples are taken H cycles into the start bit, then every `CLKS_PER_BIT` cycles.
- FSM states and transitions:
  - IDLE: on `rx_s`=0, go to START with the cycle counter at 0. If H=0, the start bit counts as verified this cycle and the FSM goes straight to DATA.
  - START: count to H, then resample. If `rx_s`=0, go to DATA. If `rx_s`=1, the low was a glitch: return to IDLE with no outputs.
  - DATA: sample every `CLKS_PER_BIT` cycles, shifting left (`shreg <= {shreg[6:0], rx_s}`) so the first bit lands in bit 7. Move to STOP after 8 samples. The bit counter is 3 bits and wraps 7→0.
  - STOP: sample once after `CLKS_PER_BIT` cycles.
    - If `rx_s`=1, complete the byte and go to IDLE.
    - If `rx_s`=0, pulse `framing_err`, discard the byte and go to BREAK.
  - BREAK: wait for `rx_s`=1, then go to IDLE. A held-low line never produces repeated frames.
- Byte completion:
  - If `valid`=0, or `valid`=1 and `ready`=1 in the same cycle: load `data` with `shreg`, set `valid`=1.
  - If `valid`=1 and `ready`=0: pulse `overrun`, keep the old `data`.
- Handshake:
  - `data` is stable while `valid`=1 and `ready`=0.
  - An accept (`valid`=1 and `ready`=1) with no completion in that cycle clears `valid` on the next edge.
  - `ready` while `valid`=0 has no effect.
- A new start bit is accepted in the cycle immediately after STOP, so back-to-back frames from `uart_tx` are received with no gap.

## Timing
- Reset values: `valid`=0, `data`=0, `framing_err`=0, `overrun`=0.
- Reset also clears internal state: FSM=IDLE, counters and `shreg` cleared, synchronizer flops set to 1.
- `RESET` mid-frame abandons the frame silently; no error pulses are produced.
- Latency with `CLKS_PER_BIT`=1 and no sync: start bit on `rx` in cycle t → data bits sampled t+1..t+8 → stop bit sampled t+9 → `valid`=1 and `data` loaded from cycle t+10.
- General latency: `valid` rises H + 9·`CLKS_PER_BIT` + 1 cycles after the first low cycle of `rx_s`.
- `framing_err` and `overrun` are registered and high for exactly one cycle, the cycle in which `valid` would otherwise have risen.

## Configuration
- `UART_RX_SYNC_EN` defined: `rx` passes through a two-flop synchronizer (both reset to 1) before the FSM. All latencies grow by 2 cycles. Use for asynchronous pins.
- `UART_RX_SYNC_EN` undefined: `rx_s` = `rx` combinationally. Use for on-chip loopback from `uart_tx`.

## Test plan
- Loopback from `uart_tx`, `CLKS_PER_BIT`=1, send 0xA5 with `ready`=1 → `valid` pulses one cycle, `data`=0xA5, 10 cycles after the start bit (12 with `UART_RX_SYNC_EN`).
- Back-to-back 0x00, 0xFF, 0x81 with no idle gap, `ready`=1 → three `valid` pulses, 10 cycles apart, bytes in order.
- Frame 0x3C with stop bit forced 0, then `rx` held low 20 cycles → one `framing_err` pulse, no `valid`, no further activity until `rx` returns high; next frame 0x5A → `data`=0x5A.
- `ready`=0, send 0x11 then 0x22 → `data` stays 0x11, `overrun` pulses at 0x22 completion; raising `ready` accepts 0x11, then `valid`=0.
- `CLKS_PER_BIT`=16, 4-cycle low glitch on idle `rx` → no frame; full frame 0xC3 → `data`=0xC3 with `valid` rising 8+144+1 cycles after the start edge.
- `RESET` asserted at the 4th data bit → all outputs 0 on the next cycle; following frame 0x7E received correctly.
